// File: rtl/mem_access_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_pkg
// Description : Shared sizes, encodings and FSM state type for mem_access_unit.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_access_pkg;

  localparam int unsigned ADDR_SIZE_DEF = 18;
  localparam int unsigned DATA_SIZE_DEF = 32;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Only full-word stores can skip the read phase of read-modify-write.
  function automatic logic is_direct_write(input logic we, input logic [1:0] size);
    return we && (size == SIZE_WORD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_lane_align
// Description : Big-endian lane extraction, load extension and store merge.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_lane_align
  import mem_access_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [DATA_SIZE-1:0] mem_word,
  input  logic [DATA_SIZE-1:0] store_data,
  output logic [DATA_SIZE-1:0] load_data,
  output logic [DATA_SIZE-1:0] merge_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // The addressed byte sits in the most significant lane of the memory word.
  assign w_byte = mem_word[DATA_SIZE-1 -: 8];
  assign w_half = mem_word[DATA_SIZE-1 -: 16];

  always_comb begin
    load_data  = mem_word;
    merge_data = store_data;
    case (size)
      SIZE_BYTE: begin
        load_data  = {{(DATA_SIZE-8){sign_ext & w_byte[7]}}, w_byte};
        merge_data = {store_data[7:0], mem_word[DATA_SIZE-9:0]};
      end
      SIZE_HALF: begin
        load_data  = {{(DATA_SIZE-16){sign_ext & w_half[15]}}, w_half};
        merge_data = {store_data[15:0], mem_word[DATA_SIZE-17:0]};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_unit
// Description : Core-to-data-memory access FSM with sub-word RMW stores.
//               Optional macro MEM_ACCESS_ALIGN_CHECK_EN rejects unaligned
//               half/word accesses.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req,
  input  logic                 we,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [ADDR_SIZE-1:0] addr,
  input  logic [DATA_SIZE-1:0] wdata,
  output logic                 ack,
  output logic                 err,
  output logic [DATA_SIZE-1:0] rdata,
  output logic                 busy,
  output logic                 data_rw,
  output logic                 ena_data,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [DATA_SIZE-1:0] mem_wdata,
  input  logic [DATA_SIZE-1:0] mem_rdata
);

  // Highest address whose four-byte window still fits in memory.
  localparam logic [ADDR_SIZE-1:0] c_addr_last = {ADDR_SIZE{1'b1}} - ADDR_SIZE'(3);

  state_t               r_state;
  logic                 r_we;
  logic [1:0]           r_size;
  logic                 r_sign_ext;
  logic [DATA_SIZE-1:0] r_wdata;

  logic                 w_misalign;
  logic                 w_reject;
  logic [DATA_SIZE-1:0] w_load_data;
  logic [DATA_SIZE-1:0] w_merge_data;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign w_misalign = ((size == SIZE_HALF) && addr[0]) ||
                      ((size == SIZE_WORD) && (addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_reject = (size == SIZE_ILLEGAL) || (addr > c_addr_last) || w_misalign;
  assign busy     = (r_state != ST_IDLE);

  mem_lane_align #(
    .DATA_SIZE (DATA_SIZE)
  ) u_lane_align (
    .size       (r_size),
    .sign_ext   (r_sign_ext),
    .mem_word   (mem_rdata),
    .store_data (r_wdata),
    .load_data  (w_load_data),
    .merge_data (w_merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_size     <= SIZE_BYTE;
      r_sign_ext <= 1'b0;
      r_wdata    <= '0;
      ack        <= 1'b0;
      err        <= 1'b0;
      data_rw    <= 1'b0;
      ena_data   <= 1'b0;
      rdata      <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      ack      <= 1'b0;
      err      <= 1'b0;
      data_rw  <= 1'b0;
      ena_data <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_we       <= we;
            r_size     <= size;
            r_sign_ext <= sign_ext;
            r_wdata    <= wdata;
            mem_addr   <= addr;
            if (w_reject) begin
              r_state <= ST_DONE;
              ack     <= 1'b1;
              err     <= 1'b1;
            end else if (is_direct_write(we, size)) begin
              r_state   <= ST_WRITE;
              data_rw   <= 1'b1;
              ena_data  <= 1'b1;
              mem_wdata <= wdata;
            end else begin
              r_state  <= ST_READ;
              ena_data <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (r_we) begin
            r_state   <= ST_WRITE;
            data_rw   <= 1'b1;
            ena_data  <= 1'b1;
            mem_wdata <= w_merge_data;
          end else begin
            r_state <= ST_DONE;
            rdata   <= w_load_data;
            ack     <= 1'b1;
          end
        end
        ST_WRITE: begin
          r_state <= ST_DONE;
          ack     <= 1'b1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_unit
// Description : Scoreboard bench for mem_access_unit with a big-endian byte memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
  import mem_access_pkg::*;

  localparam int AW = 18;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          req;
  logic          we;
  logic [1:0]    size;
  logic          sign_ext;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ack;
  logic          err;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          data_rw;
  logic          ena_data;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  logic [7:0]    mem [0:(1<<AW)-1];

  int n_checks = 0;
  int n_pass   = 0;
  logic [DW-1:0] last_rd;

  typedef struct {
    string         tag;
    int            lat;
    bit            err;
    bit            chk_rd;
    logic [DW-1:0] rd;
    int            wr;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mem_access_unit #(
    .ADDR_SIZE (AW),
    .DATA_SIZE (DW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .we        (we),
    .size      (size),
    .sign_ext  (sign_ext),
    .addr      (addr),
    .wdata     (wdata),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .busy      (busy),
    .data_rw   (data_rw),
    .ena_data  (ena_data),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  // Asynchronous-read, big-endian byte memory.
  assign mem_rdata = {mem[mem_addr], mem[mem_addr + 18'd1],
                      mem[mem_addr + 18'd2], mem[mem_addr + 18'd3]};

  always @(posedge clk) begin
    if (data_rw) begin
      mem[mem_addr]         <= mem_wdata[31:24];
      mem[mem_addr + 18'd1] <= mem_wdata[23:16];
      mem[mem_addr + 18'd2] <= mem_wdata[15:8];
      mem[mem_addr + 18'd3] <= mem_wdata[7:0];
    end
  end

  function automatic logic [31:0] mem_word(input logic [AW-1:0] a);
    return {mem[a], mem[a + 18'd1], mem[a + 18'd2], mem[a + 18'd3]};
  endfunction

  task automatic preload(input logic [AW-1:0] a, input logic [31:0] v);
    mem[a]         <= v[31:24];
    mem[a + 18'd1] <= v[23:16];
    mem[a + 18'd2] <= v[15:8];
    mem[a + 18'd3] <= v[7:0];
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Drive one request from a negedge; inputs are scrambled once req drops.
  task automatic run_access(input string tag, input logic w, input logic [1:0] sz,
                            input logic sx, input logic [AW-1:0] a, input logic [31:0] wd,
                            input int hold, input int e_lat, input bit e_err,
                            input bit chk_rd, input logic [31:0] e_rd, input int e_wr);
    exp_t e;
    exp_t got_e;
    int   lat;
    int   wr_n;
    int   en_n;
    bit   seen;
    e.tag = tag; e.lat = e_lat; e.err = e_err; e.chk_rd = chk_rd; e.rd = e_rd; e.wr = e_wr;
    sb.push_back(e);
    req = 1'b1; we = w; size = sz; sign_ext = sx; addr = a; wdata = wd;
    lat = 0; wr_n = 0; en_n = 0; seen = 1'b0;
    for (int i = 1; i <= 8 && !seen; i++) begin
      @(negedge clk);
      if (i >= hold) begin
        req = 1'b0; we = ~w; size = ~sz; sign_ext = ~sx; addr = ~a; wdata = ~wd;
      end
      wr_n += int'(data_rw);
      en_n += int'(ena_data);
      if (ack) begin
        seen = 1'b1;
        lat  = i;
      end
    end
    got_e = sb.pop_front();
    if (!seen) begin
      check_eq({got_e.tag, " ack_timeout"}, 32'd0, 32'd1);
    end else begin
      check_eq({got_e.tag, " latency"}, 32'(lat), 32'(got_e.lat));
      check_eq({got_e.tag, " err"}, {31'd0, err}, {31'd0, got_e.err});
      if (got_e.chk_rd) check_eq({got_e.tag, " rdata"}, rdata, got_e.rd);
      check_eq({got_e.tag, " data_rw_cycles"}, 32'(wr_n), 32'(got_e.wr));
      if (got_e.err) check_eq({got_e.tag, " ena_data_cycles"}, 32'(en_n), 32'd0);
      @(negedge clk);
      check_eq({got_e.tag, " ack_busy_after"}, {30'd0, ack, busy}, 32'd0);
      if (!w && !e_err) last_rd = e_rd;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_seen;
    int ack_seen;
    rst = 1'b1; req = 1'b0; we = 1'b0; size = SIZE_BYTE; sign_ext = 1'b0;
    addr = '0; wdata = '0; last_rd = '0;
    repeat (3) @(negedge clk);
    check_eq("reset ctrl", {27'd0, ack, err, busy, data_rw, ena_data}, 32'd0);
    check_eq("reset rdata", rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access("st_word", 1'b1, SIZE_WORD, 1'b0, 18'h00010, 32'hDEADBEEF, 1, 2, 1'b0, 1'b0, 32'd0, 1);
    check_eq("st_word mem", mem_word(18'h00010), 32'hDEADBEEF);
    run_access("ld_word", 1'b0, SIZE_WORD, 1'b0, 18'h00010, 32'd0, 1, 2, 1'b0, 1'b1, 32'hDEADBEEF, 0);

    preload(18'h00011, 32'h11223344);
    run_access("st_byte", 1'b1, SIZE_BYTE, 1'b0, 18'h00011, 32'h000000A5, 1, 3, 1'b0, 1'b0, 32'd0, 1);
    check_eq("st_byte mem", mem_word(18'h00011), 32'hA5223344);

    preload(18'h00020, 32'h8001CAFE);
    run_access("ld_half_sx", 1'b0, SIZE_HALF, 1'b1, 18'h00020, 32'd0, 1, 2, 1'b0, 1'b1, 32'hFFFF8001, 0);
    run_access("ld_half_zx", 1'b0, SIZE_HALF, 1'b0, 18'h00020, 32'd0, 1, 2, 1'b0, 1'b1, 32'h00008001, 0);
    run_access("ld_byte_sx_hold", 1'b0, SIZE_BYTE, 1'b1, 18'h00011, 32'd0, 2, 2, 1'b0, 1'b1, 32'hFFFFFFA5, 0);
    run_access("ld_byte_zx", 1'b0, SIZE_BYTE, 1'b0, 18'h00011, 32'd0, 1, 2, 1'b0, 1'b1, 32'h000000A5, 0);

    preload(18'h00030, 32'h12345678);
    run_access("st_half", 1'b1, SIZE_HALF, 1'b0, 18'h00030, 32'h0000BEEF, 1, 3, 1'b0, 1'b0, 32'd0, 1);
    check_eq("st_half mem", mem_word(18'h00030), 32'hBEEF5678);
    run_access("ld_word_sx_ignored", 1'b0, SIZE_WORD, 1'b1, 18'h00030, 32'd0, 1, 2, 1'b0, 1'b1, 32'hBEEF5678, 0);

    run_access("ld_out_of_range", 1'b0, SIZE_WORD, 1'b0, 18'h3FFFD, 32'd0, 1, 1, 1'b1, 1'b1, last_rd, 0);
    run_access("size_illegal", 1'b0, SIZE_ILLEGAL, 1'b0, 18'h00010, 32'd0, 1, 1, 1'b1, 1'b1, last_rd, 0);
    run_access("st_out_of_range", 1'b1, SIZE_WORD, 1'b0, 18'h3FFFD, 32'h01010101, 1, 1, 1'b1, 1'b1, last_rd, 0);
    preload(18'h3FFFC, 32'h0A0B0C0D);
    run_access("ld_last_word", 1'b0, SIZE_WORD, 1'b0, 18'h3FFFC, 32'd0, 1, 2, 1'b0, 1'b1, 32'h0A0B0C0D, 0);

    // Reset while a byte-store RMW is in its READ phase.
    preload(18'h00040, 32'h55667788);
    req = 1'b1; we = 1'b1; size = SIZE_BYTE; sign_ext = 1'b0; addr = 18'h00040; wdata = 32'h000000C3;
    @(negedge clk);
    req = 1'b0;
    check_eq("rst_mid busy_in_read", {30'd0, busy, data_rw}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rst_mid ctrl_after", {28'd0, ack, busy, data_rw, ena_data}, 32'd0);
    check_eq("rst_mid rdata_cleared", rdata, 32'd0);
    check_eq("rst_mid mem_addr_cleared", {14'd0, mem_addr}, 32'd0);
    check_eq("rst_mid mem_wdata_cleared", mem_wdata, 32'd0);
    wr_seen = 0; ack_seen = 0;
    repeat (4) begin
      @(negedge clk);
      wr_seen  += int'(data_rw);
      ack_seen += int'(ack);
    end
    check_eq("rst_mid no_write", 32'(wr_seen), 32'd0);
    check_eq("rst_mid no_ack", 32'(ack_seen), 32'd0);
    check_eq("rst_mid mem_unchanged", mem_word(18'h00040), 32'h55667788);
    last_rd = '0;

    preload(18'h00002, 32'h01020304);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    run_access("ld_unaligned", 1'b0, SIZE_WORD, 1'b0, 18'h00002, 32'd0, 1, 1, 1'b1, 1'b1, last_rd, 0);
`else
    run_access("ld_unaligned", 1'b0, SIZE_WORD, 1'b0, 18'h00002, 32'd0, 1, 2, 1'b0, 1'b1, 32'h01020304, 0);
`endif
    run_access("ld_after_reset", 1'b0, SIZE_BYTE, 1'b0, 18'h00040, 32'd0, 1, 2, 1'b0, 1'b1, 32'h00000055, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_SIZE, default 18, meaning the byte-address width shared with the data memory.
REQ-002 SHALL have parameter DATA_SIZE, default 32, meaning the word width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-005 SHALL have port req, input, 1, core access request, sampled only in IDLE.
REQ-006 SHALL have port we, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port size, input, 2, access size: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-008 SHALL have port sign_ext, input, 1, sign-extend sub-word loads when 1.
REQ-009 SHALL have port addr, input, ADDR_SIZE, core byte address.
REQ-010 SHALL have port wdata, input, DATA_SIZE, store data, right-justified.
REQ-011 SHALL have port ack, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port err, output, 1, valid with ack; access rejected.
REQ-013 SHALL have port rdata, output, DATA_SIZE, load result, registered, held until the next ack.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-015 SHALL have ports data_rw, ena_data, mem_addr (ADDR_SIZE) and mem_wdata (DATA_SIZE) as outputs, and mem_rdata (DATA_SIZE) as input, all toward the data memory.

Function
REQ-016 SHALL use a big-endian memory view: the byte at mem_addr is mem_rdata/mem_wdata[31:24], and mem_addr+3 is [7:0].
REQ-017 SHALL implement states IDLE, READ, WRITE and DONE, with memory strobes decoded from state (Moore).
REQ-018 SHALL, on req in IDLE, latch we, size, sign_ext, addr and wdata; the core may then drop or change its inputs.
REQ-019 SHALL, for a load: IDLE -> READ (ena_data=1) -> DONE, capturing extracted data into rdata; ack in DONE, 2 cycles after acceptance.
REQ-020 SHALL, for a word store: IDLE -> WRITE (data_rw=1, mem_wdata=wdata) -> DONE; ack 2 cycles after acceptance.
REQ-021 SHALL, for a byte or half store, perform read-modify-write: READ captures mem_rdata; WRITE writes it back with [31:24] (byte) or [31:16] (half) replaced by wdata[7:0] or wdata[15:0]; ack 3 cycles after acceptance.
REQ-022 SHALL, for a byte load, return mem_rdata[31:24], and for a half load return mem_rdata[31:16], zero- or sign-extended per sign_ext; a word load ignores sign_ext.
REQ-023 SHALL reject without any memory strobe when size = 11 or when addr > 2^ADDR_SIZE-4: IDLE -> DONE with ack=1, err=1, and rdata unchanged.
REQ-024 SHALL assert data_rw for exactly one cycle per store, never together with a new request acceptance; ena_data=0 and data_rw=0 in IDLE and DONE.
REQ-025 SHALL ignore req while busy=1 (no queueing), and SHALL accept a req presented in the cycle after DONE.

Reset
REQ-026 SHALL, while rst=1 at a clock edge, force IDLE with ack, err, busy, data_rw and ena_data at 0 and rdata, mem_addr and mem_wdata at 0.
REQ-027 SHALL, when reset arrives mid-operation, abandon the access with no ack and no further data_rw; an RMW interrupted before WRITE leaves memory unmodified.

Configuration
REQ-028 SHALL, with macro MEM_ACCESS_ALIGN_CHECK_EN defined, additionally reject half accesses at odd addresses and word accesses with addr[1:0] != 0, using err per REQ-023; without the macro, unaligned accesses proceed normally.

Structure
REQ-029 SHALL place the size encodings, the state enum and the ADDR_SIZE/DATA_SIZE defaults in shared package mem_access_pkg.
REQ-030 SHALL implement byte extraction, extension and merge in combinational sub-module mem_lane_align.

Verification
REQ-031 SHALL test a word store of 0xDEADBEEF at addr 0x00010, then a word load: data_rw high for 1 cycle, rdata=0xDEADBEEF, ack 2 cycles after req.
REQ-032 SHALL test a byte store of wdata=0x000000A5 at addr 0x00011 over existing word 0x11223344: the memory word at 0x00011 reads 0xA5223344, ack 3 cycles after req.
REQ-033 SHALL test a half load at a location holding 0x8001xxxx: sign_ext=1 gives 0xFFFF8001 and sign_ext=0 gives 0x00008001.
REQ-034 SHALL test a load at addr 0x3FFFD and a size=11 access: ack=err=1 one cycle after req, ena_data and data_rw stay 0.
REQ-035 SHALL test rst asserted in the READ state of a byte store: no data_rw, no ack, busy=0 next cycle, memory unchanged.
REQ-036 SHALL test a word load at addr 0x00002 with MEM_ACCESS_ALIGN_CHECK_EN: err=1; without the macro: normal data, err=0.
